// File: rtl/montgomery_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer feeding the Montgomery multiplier pipeline.
// Optional feature macro: MODEXP_FINAL_CONVERT_EN (final acc*1 multiply leaves the Montgomery domain).
module montgomery_modexp_ctrl #(
    parameter int W     = 64,
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             start_ready,
    input  logic [W-1:0]     base_m,
    input  logic [W-1:0]     one_m,
    input  logic [W-1:0]     exp,
    input  logic [LEN_W-1:0] exp_len,
    output logic             res_valid,
    output logic [W-1:0]     res,
    input  logic             res_ack,
    output logic [W-1:0]     mm_a,
    output logic [W-1:0]     mm_b,
    output logic             mm_taken,
    input  logic             mm_ready_in,
    input  logic [W-1:0]     mm_result,
    input  logic             mm_ready_out,
    output logic             mm_given
);

    typedef enum logic [2:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
`ifdef MODEXP_FINAL_CONVERT_EN
        CONV_ISSUE,
        CONV_WAIT,
`endif
        DONE
    } state_t;

`ifdef MODEXP_FINAL_CONVERT_EN
    localparam state_t LOOP_EXIT = CONV_ISSUE;
`else
    localparam state_t LOOP_EXIT = DONE;
`endif

    localparam logic [LEN_W-1:0] W_L = LEN_W'(W);

    state_t             state_reg, state_next;
    logic [W-1:0]       acc_reg, base_reg, exp_reg;
    logic [LEN_W-1:0]   idx_reg;
    logic               start_ready_reg, res_valid_reg;
    logic [W-1:0]       res_reg, mm_a_reg, mm_b_reg;
    logic               mm_taken_reg, mm_given_reg;

    logic               accept, issue_fire, capture, bit_done, drain, idx_last;
    logic [W-1:0]       issue_b;
    logic [LEN_W-1:0]   len_clamped;

    assign len_clamped = (exp_len > W_L) ? W_L : exp_len;
    assign idx_last    = (idx_reg == LEN_W'(1));
    assign accept      = start && start_ready_reg && (state_reg == IDLE);
    // An orphaned product (e.g. after a reset mid-run) is acknowledged and dropped.
    assign drain       = (state_reg == IDLE) && mm_ready_out && !mm_given_reg;

    always_comb begin
        state_next = state_reg;
        issue_fire = 1'b0;
        capture    = 1'b0;
        bit_done   = 1'b0;
        issue_b    = acc_reg;
        case (state_reg)
            IDLE: begin
                if (accept)
                    state_next = (len_clamped == '0) ? LOOP_EXIT : SQ_ISSUE;
            end
            SQ_ISSUE: begin
                if (mm_ready_in) begin
                    issue_fire = 1'b1;
                    state_next = SQ_WAIT;
                end
            end
            // In a wait state mm_given_reg marks the acknowledge cycle that follows capture.
            SQ_WAIT: begin
                if (mm_given_reg) begin
                    if (exp_reg[W-1]) begin
                        state_next = MUL_ISSUE;
                    end else begin
                        bit_done   = 1'b1;
                        state_next = idx_last ? LOOP_EXIT : SQ_ISSUE;
                    end
                end else if (mm_ready_out) begin
                    capture = 1'b1;
                end
            end
            MUL_ISSUE: begin
                issue_b = base_reg;
                if (mm_ready_in) begin
                    issue_fire = 1'b1;
                    state_next = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (mm_given_reg) begin
                    bit_done   = 1'b1;
                    state_next = idx_last ? LOOP_EXIT : SQ_ISSUE;
                end else if (mm_ready_out) begin
                    capture = 1'b1;
                end
            end
`ifdef MODEXP_FINAL_CONVERT_EN
            CONV_ISSUE: begin
                issue_b = W'(1);
                if (mm_ready_in) begin
                    issue_fire = 1'b1;
                    state_next = CONV_WAIT;
                end
            end
            CONV_WAIT: begin
                if (mm_given_reg)
                    state_next = DONE;
                else if (mm_ready_out)
                    capture = 1'b1;
            end
`endif
            DONE: begin
                if (res_valid_reg && res_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            start_ready_reg <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_reg         <= '0;
            mm_a_reg        <= '0;
            mm_b_reg        <= '0;
            mm_taken_reg    <= 1'b0;
            mm_given_reg    <= 1'b0;
            acc_reg         <= '0;
            base_reg        <= '0;
            exp_reg         <= '0;
            idx_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            start_ready_reg <= (state_next == IDLE);
            mm_taken_reg    <= issue_fire;
            mm_given_reg    <= capture || drain;
            if (issue_fire) begin
                mm_a_reg <= acc_reg;
                mm_b_reg <= issue_b;
            end
            // Exponent is left-aligned so the bit under test is always the MSB.
            if (accept) begin
                acc_reg  <= one_m;
                base_reg <= base_m;
                exp_reg  <= exp << (W_L - len_clamped);
                idx_reg  <= len_clamped;
            end
            if (capture)
                acc_reg <= mm_result;
            if (bit_done) begin
                idx_reg <= idx_reg - LEN_W'(1);
                exp_reg <= exp_reg << 1;
            end
            if (state_reg == DONE && !res_valid_reg) begin
                res_valid_reg <= 1'b1;
                res_reg       <= acc_reg;
            end else if (res_valid_reg && res_ack) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign start_ready = start_ready_reg;
    assign res_valid   = res_valid_reg;
    assign res         = res_reg;
    assign mm_a        = mm_a_reg;
    assign mm_b        = mm_b_reg;
    assign mm_taken    = mm_taken_reg;
    assign mm_given    = mm_given_reg;

endmodule

// File: tb/tb_montgomery_modexp_ctrl.sv
// Directed bench for montgomery_modexp_ctrl with a latency-3 (a*b mod 2^64) stub multiplier
// and a scoreboard of expected results and multiply counts.
`timescale 1ns/1ps
module tb_montgomery_modexp_ctrl;
    localparam int W     = 64;
    localparam int LEN_W = 7;
    localparam int LAT   = 3;
`ifdef MODEXP_FINAL_CONVERT_EN
    localparam int CONV = 1;
`else
    localparam int CONV = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             start_ready;
    logic [W-1:0]     base_m = '0;
    logic [W-1:0]     one_m = '0;
    logic [W-1:0]     exp = '0;
    logic [LEN_W-1:0] exp_len = '0;
    logic             res_valid;
    logic [W-1:0]     res;
    logic             res_ack = 1'b0;
    logic [W-1:0]     mm_a, mm_b;
    logic             mm_taken;
    logic             mm_ready_in = 1'b1;
    logic [W-1:0]     mm_result = '0;
    logic             mm_ready_out = 1'b0;
    logic             mm_given;

    always #5 clk = ~clk;

    montgomery_modexp_ctrl #(.W(W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .base_m(base_m), .one_m(one_m), .exp(exp), .exp_len(exp_len),
        .res_valid(res_valid), .res(res), .res_ack(res_ack),
        .mm_a(mm_a), .mm_b(mm_b), .mm_taken(mm_taken), .mm_ready_in(mm_ready_in),
        .mm_result(mm_result), .mm_ready_out(mm_ready_out), .mm_given(mm_given)
    );

    // Stub multiplier: captures on mm_taken, presents the product LAT cycles later.
    logic [W-1:0] stub_val = '0;
    logic         stub_pending = 1'b0;
    int           stub_cnt = 0;
    always @(posedge clk) begin
        if (mm_given) mm_ready_out <= 1'b0;
        if (mm_taken) begin
            stub_pending <= 1'b1;
            stub_cnt     <= LAT - 1;
            stub_val     <= mm_a * mm_b;
        end else if (stub_pending) begin
            if (stub_cnt == 0) begin
                stub_pending <= 1'b0;
                mm_ready_out <= 1'b1;
                mm_result    <= stub_val;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    int           taken_cnt = 0, given_cnt = 0, overlap_cnt = 0;
    logic [W-1:0] last_a = '0, last_b = '0;
    always @(posedge clk) begin
        if (mm_taken) begin
            taken_cnt <= taken_cnt + 1;
            last_a    <= mm_a;
            last_b    <= mm_b;
        end
        if (mm_given) given_cnt <= given_cnt + 1;
        if (mm_taken && mm_given) overlap_cnt <= overlap_cnt + 1;
    end

    int           checks = 0, passed = 0, failed = 0;
    logic [W-1:0] sb_res_q[$];
    int           sb_pulse_q[$];
    int           run_taken_base = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model_res(input logic [63:0] b, input logic [63:0] one,
                                              input logic [63:0] e, input int len);
        logic [63:0] acc;
        int n;
        acc = one;
        n = (len > W) ? W : len;
        for (int i = n - 1; i >= 0; i--) begin
            acc = acc * acc;
            if (e[i]) acc = acc * b;
        end
        return acc;  // acc*1 conversion leaves the value unchanged under the stub
    endfunction

    function automatic int model_pulses(input logic [63:0] e, input int len);
        int n, cnt;
        n = (len > W) ? W : len;
        cnt = n + CONV;
        for (int i = 0; i < n; i++) if (e[i]) cnt++;
        return cnt;
    endfunction

    task automatic start_run(input logic [63:0] b, input logic [63:0] one,
                             input logic [63:0] e, input logic [LEN_W-1:0] len);
        int guard;
        guard = 0;
        while (!start_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("start_ready_before_start", 64'(start_ready), 64'd1);
        base_m  = b;
        one_m   = one;
        exp     = e;
        exp_len = len;
        start   = 1'b1;
        sb_res_q.push_back(model_res(b, one, e, int'(len)));
        sb_pulse_q.push_back(model_pulses(e, int'(len)));
        run_taken_base = taken_cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input string name);
        int guard;
        logic [63:0] exp_res, held;
        int exp_p;
        guard = 0;
        while (!res_valid && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_res_valid_timeout"}, 64'(res_valid), 64'd1);
        exp_res = sb_res_q.pop_front();
        exp_p   = sb_pulse_q.pop_front();
        check({name, "_res"}, res, exp_res);
        check({name, "_taken_pulses"}, 64'(taken_cnt - run_taken_base), 64'(exp_p));
        held = res;
        repeat (3) @(negedge clk);
        check({name, "_res_valid_held"}, 64'(res_valid), 64'd1);
        check({name, "_res_stable"}, res, held);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        check({name, "_res_valid_after_ack"}, 64'(res_valid), 64'd0);
        $display("txn %s: res=0x%0h expected=0x%0h pulses=%0d expected=%0d",
                 name, held, exp_res, taken_cnt - run_taken_base, exp_p);
    endtask

    initial begin
        logic [63:0] a0, b0;
        int tbase, gbase, guard;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_start_ready", 64'(start_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res", res, 64'd0);
        check("rst_mm_taken", 64'(mm_taken), 64'd0);
        check("rst_mm_given", 64'(mm_given), 64'd0);
        check("rst_mm_a", mm_a, 64'd0);
        check("rst_mm_b", mm_b, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_start_ready", 64'(start_ready), 64'd1);

        // Basic 3^5
        start_run(64'd3, 64'd1, 64'd5, 7'd3);
        finish_run("pow3_5");
`ifdef MODEXP_FINAL_CONVERT_EN
        check("conv_last_a", last_a, 64'hF3);
        check("conv_last_b", last_b, 64'd1);
`endif

        // exp_len = 0
        start_run(64'd3, 64'h1234, 64'd5, 7'd0);
        check("len0_res_valid_1cyc", 64'(res_valid), 64'd0);
`ifndef MODEXP_FINAL_CONVERT_EN
        @(negedge clk);
        check("len0_res_valid_2cyc", 64'(res_valid), 64'd1);
`endif
        finish_run("len0");

        // Backpressure on issue
        mm_ready_in = 1'b0;
        start_run(64'd3, 64'd5, 64'd5, 7'd3);
        a0 = mm_a;
        b0 = mm_b;
        tbase = taken_cnt;
        repeat (10) begin
            @(negedge clk);
            check("stall_no_taken", 64'(mm_taken), 64'd0);
        end
        check("stall_taken_count", 64'(taken_cnt - tbase), 64'd0);
        check("stall_mm_a_hold", mm_a, a0);
        check("stall_mm_b_hold", mm_b, b0);
        mm_ready_in = 1'b1;
        @(negedge clk);
        check("stall_release_taken", 64'(mm_taken), 64'd1);
        check("stall_release_a", mm_a, 64'd5);
        check("stall_release_b", mm_b, 64'd5);
        finish_run("stall");

        // Reset while SQ_WAIT, then stale drain
        start_run(64'd3, 64'd1, 64'd5, 7'd3);
        guard = 0;
        while (!mm_taken && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("abort_taken_seen", 64'(mm_taken), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_start_ready", 64'(start_ready), 64'd0);
        check("abort_res_valid", 64'(res_valid), 64'd0);
        check("abort_res", res, 64'd0);
        check("abort_mm_taken", 64'(mm_taken), 64'd0);
        check("abort_mm_given", 64'(mm_given), 64'd0);
        check("abort_mm_a", mm_a, 64'd0);
        check("abort_mm_b", mm_b, 64'd0);
        sb_res_q.delete();
        sb_pulse_q.delete();
        gbase = given_cnt;
        repeat (10) @(negedge clk);
        check("drain_given_count", 64'(given_cnt - gbase), 64'd1);
        check("drain_ready_out_low", 64'(mm_ready_out), 64'd0);
        start_run(64'd2, 64'd1, 64'd10, 7'd4);
        finish_run("pow2_10");

        // Start and res_ack while busy are ignored
        start_run(64'd3, 64'd1, 64'd5, 7'd3);
        base_m  = 64'd7;
        exp     = '1;
        exp_len = 7'd8;
        start   = 1'b1;
        res_ack = 1'b1;
        repeat (3) @(negedge clk);
        start   = 1'b0;
        res_ack = 1'b0;
        finish_run("busy_ignore");

        // Bits above exp_len ignored; exp_len above W clamped
        start_run(64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFF5, 7'd3);
        finish_run("high_bits");
        start_run(64'd3, 64'd1, 64'd1, 7'd100);
        finish_run("clamp");

        // A few random exponents
        for (int k = 0; k < 3; k++) begin
            start_run({$urandom, $urandom}, 64'($urandom_range(1, 50)), {$urandom, $urandom},
                      7'($urandom_range(1, 10)));
            finish_run("random");
        end

        check("no_taken_given_overlap", 64'(overlap_cnt), 64'd0);
        check("scoreboard_empty", 64'(sb_res_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
